aes_key_sched: RTL and testbench
================================

# aes_key_sched

On-the-fly AES-128 round-key generator sitting directly downstream of the AES round controller. It consumes the controller's start strobe and one-hot round flags and presents, in the same cycle as each flag, the 128-bit round key that the datapath needs. It then advances to the next round key at the clock edge. It also flags any flag sequence that departs from the Init, Fst, 8×Mid, Lst, Done order.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10), fixed by the package constants.
- iClk  in  1  clock; all state updates on the rising edge.
- iRsn  in  1  reset, synchronous and active-low.
- iStAes  in  1  start strobe, the same signal the controller samples; captures iKey when idle.
- iKey  in  128  cipher key, byte 0 in [127:120]; sampled only on an accepted iStAes.
- iInitRoundFlag, iFstRoundFlag, iMidRoundFlag, iLstRoundFlag, iAesDone  in  1 each  controller state flags, one-hot or all-low.
- oRoundKey  out  128  current round key, registered.
- oRoundIdx  out  4  index of the key on oRoundKey, 0..10.
- oRoundKeyVld  out  1  high while a loaded key sequence is active (from load until Done).
- oSeqErr  out  1  sticky flow-violation flag.

## Operation
- The state register rBusy has two states.
  - IDLE to BUSY: iStAes=1 while IDLE. Load rKey←iKey, rIdx←0, rRcon←8'h01, clear oSeqErr.
  - BUSY to IDLE: iAesDone=1 or oSeqErr being set.
  - iStAes while BUSY is ignored, with no reload.
- Advance rule: in BUSY, any of the Init, Fst or Mid flags causes the following at the clock edge:
  - rKey←expand(rKey, rRcon)
  - rIdx←rIdx+1
  - rRcon←xtime(rRcon), where xtime is a left shift with conditional XOR of 8'h1B
- The Lst flag does not advance, and neither does Done.
- expand() is the standard AES-128 key expansion:
  - t = SubWord(RotWord(w3)) ^ {rRcon,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - w0 is [127:96].
- The rcon sequence must reach 01,02,04,08,10,20,40,80,1B,36 for idx 0..9.
- Expected flag/index pairing; any mismatch sets oSeqErr:
  - Init at idx 0
  - Fst at idx 1
  - Mid at idx 2..9
  - Lst at idx 10
  - Done at idx 10
- oSeqErr is also set by:
  - more than one flag high in the same cycle
  - any flag while IDLE
- oSeqErr stays set until the next accepted iStAes or reset.
- rIdx saturates at 10 and never wraps.

## Timing
- Reset values: oRoundKey=0, oRoundIdx=0, oRoundKeyVld=0, oSeqErr=0; internally rRcon=8'h01 and state IDLE.
- Reset mid-operation returns to these values on the next edge; the abandoned key is discarded.
- Key load: iStAes at edge N puts key0 on oRoundKey from cycle N+1, which is the controller's Init cycle. Zero bubble.
- Per round: key k is valid during the flag cycle for round k. Key k+1 appears on the edge ending that cycle. Latency is one cycle per round, with no stalls.
- Simultaneous iStAes and iAesDone in BUSY: Done wins, the state goes to IDLE and the start is ignored.
- oRoundKeyVld drops on the edge after the iAesDone cycle.
- iStAes in the cycle right after Done is accepted normally.

## Configuration
- AES_KEY_ZEROIZE_EN
  - Defined: on leaving BUSY (Done or error), rKey and oRoundKey clear to 0 and oRoundIdx to 0 at that same edge.
  - Undefined: the last round key (idx 10) remains on oRoundKey until the next load.
- oSeqErr and oRoundKeyVld behaviour is identical in both builds.

## Structure
- The shared package aes_pkg holds:
  - AES_KEY_W=128, AES_NR=10, AES_RCON_INIT=8'h01, AES_XTIME_POLY=8'h1B
  - the round-index width and constants IDX_INIT=0, IDX_FST=1, IDX_LST=10
- One sub-module: aes_sbox, an 8-bit combinational S-box, instantiated four times for SubWord. The same module is reused by the datapath SubBytes.
- Everything else stays in aes_key_sched.

## Test plan
- FIPS-197 A.1: iKey=2b7e151628aed2a6abf7158809cf4f3c, then the nominal flag sequence. Required outputs:
  - Init: idx0 key = the input key
  - Fst: a0fafe1788542cb123a339392a6c7605
  - Lst: idx10 d014f9a8c9ee2589e13f0cc8b6630ca6
  - oSeqErr=0 throughout
- Back-to-back runs: a second iStAes one cycle after Done with key 000102…0f. Round-10 key = 13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 C.1); idx restarts at 0.
- Protocol error: drop one Mid cycle so Lst arrives at idx 9. Required: oSeqErr=1 on the next edge, Vld=0, and a stable error until a new iStAes clears it.
- Double flag: Fst and Mid high together at idx 1. Required: oSeqErr=1.
- Reset at idx 5: iRsn=0 for one edge. Required: all outputs at reset values the next cycle; a restart produces the correct key sequence.
- Zeroize build: with AES_KEY_ZEROIZE_EN, oRoundKey=0 the cycle after Done. Without it, the output holds d014f9a8….

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-schedule state type and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_NR    = 10;

  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_XTIME_POLY = 8'h1B;

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_INIT   = 4'd0;
  localparam logic [IDX_W-1:0] IDX_FST    = 4'd1;
  localparam logic [IDX_W-1:0] IDX_MID_LO = 4'd2;
  localparam logic [IDX_W-1:0] IDX_MID_HI = 4'd9;
  localparam logic [IDX_W-1:0] IDX_LST    = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_XTIME_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  logic [7:0] inv;
  logic [7:0] pw;

  // x^254 = product of x^(2^i) for i = 1..7; maps 0 to 0 as the S-box requires.
  always_comb begin
    inv = 8'h01;
    pw  = data;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    subst = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched.sv
// On-the-fly AES-128 round-key generator with round-flag sequence checking.
// Optional build macro: AES_KEY_ZEROIZE_EN clears the key and index on leaving BUSY.
module aes_key_sched
  import aes_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRsn,
  input  logic                 iStAes,
  input  logic [AES_KEY_W-1:0] iKey,
  input  logic                 iInitRoundFlag,
  input  logic                 iFstRoundFlag,
  input  logic                 iMidRoundFlag,
  input  logic                 iLstRoundFlag,
  input  logic                 iAesDone,
  output logic [AES_KEY_W-1:0] oRoundKey,
  output logic [IDX_W-1:0]     oRoundIdx,
  output logic                 oRoundKeyVld,
  output logic                 oSeqErr
);

`ifdef AES_KEY_ZEROIZE_EN
  localparam logic ZEROIZE = 1'b1;
`else
  localparam logic ZEROIZE = 1'b0;
`endif

  ks_state_e            state, state_next;
  logic [AES_KEY_W-1:0] key, key_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [7:0]           rcon, rcon_next;
  logic                 seq_err, seq_err_next;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, tw;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data  (rot[8*b +: 8]),
      .subst (sub[8*b +: 8])
    );
  end

  assign tw = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ tw;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  logic [4:0] flags;
  logic       any_flag, multi_flag, order_err, advance, leave;

  assign flags      = {iAesDone, iLstRoundFlag, iMidRoundFlag, iFstRoundFlag, iInitRoundFlag};
  assign any_flag   = |flags;
  assign multi_flag = (flags & (flags - 5'd1)) != 5'd0;
  assign advance    = iInitRoundFlag | iFstRoundFlag | iMidRoundFlag;

  // Each flag is legal only at the round index the controller should be on.
  assign order_err = (iInitRoundFlag && idx != IDX_INIT)
                  || (iFstRoundFlag  && idx != IDX_FST)
                  || (iMidRoundFlag  && (idx < IDX_MID_LO || idx > IDX_MID_HI))
                  || (iLstRoundFlag  && idx != IDX_LST)
                  || (iAesDone       && idx != IDX_LST);

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state   <= IDLE;
      key     <= '0;
      idx     <= '0;
      rcon    <= AES_RCON_INIT;
      seq_err <= 1'b0;
    end else begin
      state   <= state_next;
      key     <= key_next;
      idx     <= idx_next;
      rcon    <= rcon_next;
      seq_err <= seq_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    key_next     = key;
    idx_next     = idx;
    rcon_next    = rcon;
    seq_err_next = seq_err;
    leave        = 1'b0;
    case (state)
      IDLE: begin
        if (any_flag) begin
          seq_err_next = 1'b1;
        end else if (iStAes) begin
          state_next   = BUSY;
          key_next     = iKey;
          idx_next     = IDX_INIT;
          rcon_next    = AES_RCON_INIT;
          seq_err_next = 1'b0;
        end
      end
      BUSY: begin
        if (multi_flag || order_err) begin
          seq_err_next = 1'b1;
          state_next   = IDLE;
          leave        = 1'b1;
        end else if (iAesDone) begin
          state_next = IDLE;
          leave      = 1'b1;
        end else if (advance) begin
          key_next  = {n0, n1, n2, n3};
          idx_next  = (idx == IDX_LST) ? idx : idx + 4'd1;
          rcon_next = xtime(rcon);
        end
      end
      default: state_next = IDLE;
    endcase
    if (ZEROIZE && leave) begin
      key_next = '0;
      idx_next = '0;
    end
  end

  assign oRoundKey    = key;
  assign oRoundIdx    = idx;
  assign oRoundKeyVld = (state == BUSY);
  assign oSeqErr      = seq_err;

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched using FIPS-197 A.1 / C.1 key schedules.
// Honours AES_KEY_ZEROIZE_EN when it is defined for the build.
module tb_aes_key_sched;

`ifdef AES_KEY_ZEROIZE_EN
  localparam logic ZEROIZE = 1'b1;
`else
  localparam logic ZEROIZE = 1'b0;
`endif

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_K1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_INIT = 5'b00001;
  localparam logic [4:0] F_FST  = 5'b00010;
  localparam logic [4:0] F_MID  = 5'b00100;
  localparam logic [4:0] F_LST  = 5'b01000;
  localparam logic [4:0] F_DONE = 5'b10000;

  typedef struct packed {
    logic [3:0]   idx;
    logic         vld;
    logic         err;
    logic         chk;
    logic [127:0] key;
  } exp_t;

  typedef struct packed {
    logic         rsn;
    logic         st;
    logic [127:0] key;
    logic [4:0]   fl;
    exp_t         e;
  } step_t;

  logic         clk = 1'b0;
  logic         iRsn = 1'b0;
  logic         iStAes = 1'b0;
  logic [127:0] iKey = '0;
  logic         iInitRoundFlag = 1'b0, iFstRoundFlag = 1'b0, iMidRoundFlag = 1'b0;
  logic         iLstRoundFlag = 1'b0, iAesDone = 1'b0;
  logic [127:0] oRoundKey;
  logic [3:0]   oRoundIdx;
  logic         oRoundKeyVld, oSeqErr;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  aes_key_sched dut (
    .iClk           (clk),
    .iRsn           (iRsn),
    .iStAes         (iStAes),
    .iKey           (iKey),
    .iInitRoundFlag (iInitRoundFlag),
    .iFstRoundFlag  (iFstRoundFlag),
    .iMidRoundFlag  (iMidRoundFlag),
    .iLstRoundFlag  (iLstRoundFlag),
    .iAesDone       (iAesDone),
    .oRoundKey      (oRoundKey),
    .oRoundIdx      (oRoundIdx),
    .oRoundKeyVld   (oRoundKeyVld),
    .oSeqErr        (oSeqErr)
  );

  function automatic step_t mk(input logic rsn, input logic st, input logic [127:0] k,
                               input logic [4:0] fl, input logic [3:0] idx, input logic vld,
                               input logic err, input logic chk, input logic [127:0] ek);
    step_t r;
    r.rsn   = rsn;
    r.st    = st;
    r.key   = k;
    r.fl    = fl;
    r.e.idx = idx;
    r.e.vld = vld;
    r.e.err = err;
    r.e.chk = chk;
    r.e.key = ek;
    return r;
  endfunction

  // Step s of a clean run: 0 Init, 1 Fst, 2..9 Mid, 10 Lst, 11 Done.
  function automatic step_t nom_step(input int s, input logic [127:0] k0,
                                     input logic [127:0] k1, input logic [127:0] k10);
    logic [4:0]   fl;
    logic [127:0] ek;
    if (s == 0)       fl = F_INIT;
    else if (s == 1)  fl = F_FST;
    else if (s <= 9)  fl = F_MID;
    else if (s == 10) fl = F_LST;
    else              fl = F_DONE;
    ek = (s == 0) ? k0 : (s == 1) ? k1 : k10;
    return mk(1'b1, 1'b0, ~k0, fl, (s > 10) ? 4'd10 : 4'(s), 1'b1, 1'b0,
              (s <= 1 || s >= 10) ? 1'b1 : 1'b0, ek);
  endfunction

  task automatic drive(input step_t t);
    @(posedge clk);
    #1;
    iRsn   = t.rsn;
    iStAes = t.st;
    iKey   = t.key;
    {iAesDone, iLstRoundFlag, iMidRoundFlag, iFstRoundFlag, iInitRoundFlag} = t.fl;
  endtask

  task automatic test_reset();
    step_t tab[$];
    exp_t  e;
    tab.push_back(mk(1'b0, 1'b1, KEY_A1, F_INIT, 4'd0, 1'b0, 1'b0, 1'b1, '0));
    tab.push_back(mk(1'b0, 1'b0, KEY_C1, F_NONE, 4'd0, 1'b0, 1'b0, 1'b1, '0));
    foreach (tab[i]) begin
      drive(tab[i]);
      exp_q.push_back(tab[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({oRoundIdx, oRoundKeyVld, oSeqErr} !== {e.idx, e.vld, e.err}) begin
        n_fail++;
        $display("[TB] FAIL reset ctl step %0d: got idx=%0d vld=%b err=%b, want idx=%0d vld=%b err=%b",
                 i, oRoundIdx, oRoundKeyVld, oSeqErr, e.idx, e.vld, e.err);
      end
      if (e.chk) begin
        n_cmp++;
        if (oRoundKey !== e.key) begin
          n_fail++;
          $display("[TB] FAIL reset key step %0d: got %h, want %h", i, oRoundKey, e.key);
        end
      end
    end
  endtask

  task automatic test_fips_a1();
    step_t tab[$];
    exp_t  e;
    tab.push_back(mk(1'b1, 1'b1, KEY_A1, F_NONE, 4'd0, 1'b0, 1'b0, 1'b1, '0));
    for (int s = 0; s < 12; s++) tab.push_back(nom_step(s, KEY_A1, A1_K1, A1_K10));
    foreach (tab[i]) begin
      drive(tab[i]);
      exp_q.push_back(tab[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({oRoundIdx, oRoundKeyVld, oSeqErr} !== {e.idx, e.vld, e.err}) begin
        n_fail++;
        $display("[TB] FAIL a1 ctl step %0d: got idx=%0d vld=%b err=%b, want idx=%0d vld=%b err=%b",
                 i, oRoundIdx, oRoundKeyVld, oSeqErr, e.idx, e.vld, e.err);
      end
      if (e.chk) begin
        n_cmp++;
        if (oRoundKey !== e.key) begin
          n_fail++;
          $display("[TB] FAIL a1 key step %0d: got %h, want %h", i, oRoundKey, e.key);
        end
      end
    end
  endtask

  // Start lands in the cycle right after Done; the first sample shows the post-Done hold.
  task automatic test_back_to_back();
    step_t tab[$];
    exp_t  e;
    tab.push_back(mk(1'b1, 1'b1, KEY_C1, F_NONE, ZEROIZE ? 4'd0 : 4'd10, 1'b0, 1'b0, 1'b1,
                     ZEROIZE ? 128'h0 : A1_K10));
    for (int s = 0; s < 12; s++) tab.push_back(nom_step(s, KEY_C1, C1_K1, C1_K10));
    foreach (tab[i]) begin
      drive(tab[i]);
      exp_q.push_back(tab[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({oRoundIdx, oRoundKeyVld, oSeqErr} !== {e.idx, e.vld, e.err}) begin
        n_fail++;
        $display("[TB] FAIL b2b ctl step %0d: got idx=%0d vld=%b err=%b, want idx=%0d vld=%b err=%b",
                 i, oRoundIdx, oRoundKeyVld, oSeqErr, e.idx, e.vld, e.err);
      end
      if (e.chk) begin
        n_cmp++;
        if (oRoundKey !== e.key) begin
          n_fail++;
          $display("[TB] FAIL b2b key step %0d: got %h, want %h", i, oRoundKey, e.key);
        end
      end
    end
  endtask

  task automatic test_seq_err();
    step_t       tab[$];
    exp_t        e;
    logic [3:0]  hold_idx;
    hold_idx = ZEROIZE ? 4'd0 : 4'd9;
    tab.push_back(mk(1'b1, 1'b1, KEY_A1, F_NONE, ZEROIZE ? 4'd0 : 4'd10, 1'b0, 1'b0, 1'b1,
                     ZEROIZE ? 128'h0 : C1_K10));
    for (int s = 0; s < 9; s++) tab.push_back(nom_step(s, KEY_A1, A1_K1, A1_K10));
    tab.push_back(mk(1'b1, 1'b0, '1, F_LST,  4'd9,     1'b1, 1'b0, 1'b0, '0));
    tab.push_back(mk(1'b1, 1'b0, '1, F_NONE, hold_idx, 1'b0, 1'b1, ZEROIZE, '0));
    tab.push_back(mk(1'b1, 1'b0, '1, F_DONE, hold_idx, 1'b0, 1'b1, ZEROIZE, '0));
    tab.push_back(mk(1'b1, 1'b0, '1, F_INIT, hold_idx, 1'b0, 1'b1, ZEROIZE, '0));
    tab.push_back(mk(1'b1, 1'b0, '1, F_NONE, hold_idx, 1'b0, 1'b1, ZEROIZE, '0));
    tab.push_back(mk(1'b1, 1'b1, KEY_C1, F_NONE, hold_idx, 1'b0, 1'b1, ZEROIZE, '0));
    tab.push_back(mk(1'b1, 1'b0, '1, F_INIT, 4'd0, 1'b1, 1'b0, 1'b1, KEY_C1));
    tab.push_back(mk(1'b1, 1'b0, '1, F_DONE, 4'd1, 1'b1, 1'b0, 1'b1, C1_K1));
    tab.push_back(mk(1'b1, 1'b0, '1, F_NONE, ZEROIZE ? 4'd0 : 4'd1, 1'b0, 1'b1, 1'b1,
                     ZEROIZE ? 128'h0 : C1_K1));
    foreach (tab[i]) begin
      drive(tab[i]);
      exp_q.push_back(tab[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({oRoundIdx, oRoundKeyVld, oSeqErr} !== {e.idx, e.vld, e.err}) begin
        n_fail++;
        $display("[TB] FAIL seqerr ctl step %0d: got idx=%0d vld=%b err=%b, want idx=%0d vld=%b err=%b",
                 i, oRoundIdx, oRoundKeyVld, oSeqErr, e.idx, e.vld, e.err);
      end
      if (e.chk) begin
        n_cmp++;
        if (oRoundKey !== e.key) begin
          n_fail++;
          $display("[TB] FAIL seqerr key step %0d: got %h, want %h", i, oRoundKey, e.key);
        end
      end
    end
  endtask

  task automatic test_double_flag();
    step_t tab[$];
    exp_t  e;
    tab.push_back(mk(1'b1, 1'b1, KEY_C1, F_NONE, ZEROIZE ? 4'd0 : 4'd1, 1'b0, 1'b1, 1'b1,
                     ZEROIZE ? 128'h0 : C1_K1));
    tab.push_back(mk(1'b1, 1'b0, '0, F_INIT, 4'd0, 1'b1, 1'b0, 1'b1, KEY_C1));
    tab.push_back(mk(1'b1, 1'b0, '0, F_FST | F_MID, 4'd1, 1'b1, 1'b0, 1'b1, C1_K1));
    tab.push_back(mk(1'b1, 1'b0, '0, F_NONE, ZEROIZE ? 4'd0 : 4'd1, 1'b0, 1'b1, 1'b1,
                     ZEROIZE ? 128'h0 : C1_K1));
    foreach (tab[i]) begin
      drive(tab[i]);
      exp_q.push_back(tab[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({oRoundIdx, oRoundKeyVld, oSeqErr} !== {e.idx, e.vld, e.err}) begin
        n_fail++;
        $display("[TB] FAIL dbl ctl step %0d: got idx=%0d vld=%b err=%b, want idx=%0d vld=%b err=%b",
                 i, oRoundIdx, oRoundKeyVld, oSeqErr, e.idx, e.vld, e.err);
      end
      if (e.chk) begin
        n_cmp++;
        if (oRoundKey !== e.key) begin
          n_fail++;
          $display("[TB] FAIL dbl key step %0d: got %h, want %h", i, oRoundKey, e.key);
        end
      end
    end
  endtask

  // Reset at idx 5, clean restart, then Done with a simultaneous start that must be ignored.
  task automatic test_mid_reset();
    step_t tab[$];
    step_t t;
    exp_t  e;
    tab.push_back(mk(1'b1, 1'b1, KEY_A1, F_NONE, ZEROIZE ? 4'd0 : 4'd1, 1'b0, 1'b1, 1'b1,
                     ZEROIZE ? 128'h0 : C1_K1));
    for (int s = 0; s < 5; s++) tab.push_back(nom_step(s, KEY_A1, A1_K1, A1_K10));
    tab.push_back(mk(1'b0, 1'b0, '1, F_MID,  4'd5, 1'b1, 1'b0, 1'b0, '0));
    tab.push_back(mk(1'b1, 1'b0, '1, F_NONE, 4'd0, 1'b0, 1'b0, 1'b1, '0));
    tab.push_back(mk(1'b1, 1'b1, KEY_A1, F_NONE, 4'd0, 1'b0, 1'b0, 1'b1, '0));
    for (int s = 0; s < 12; s++) begin
      t = nom_step(s, KEY_A1, A1_K1, A1_K10);
      if (s == 11) begin
        t.st  = 1'b1;
        t.key = KEY_C1;
      end
      tab.push_back(t);
    end
    for (int s = 0; s < 2; s++)
      tab.push_back(mk(1'b1, 1'b0, '0, F_NONE, ZEROIZE ? 4'd0 : 4'd10, 1'b0, 1'b0, 1'b1,
                       ZEROIZE ? 128'h0 : A1_K10));
    foreach (tab[i]) begin
      drive(tab[i]);
      exp_q.push_back(tab[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({oRoundIdx, oRoundKeyVld, oSeqErr} !== {e.idx, e.vld, e.err}) begin
        n_fail++;
        $display("[TB] FAIL rst5 ctl step %0d: got idx=%0d vld=%b err=%b, want idx=%0d vld=%b err=%b",
                 i, oRoundIdx, oRoundKeyVld, oSeqErr, e.idx, e.vld, e.err);
      end
      if (e.chk) begin
        n_cmp++;
        if (oRoundKey !== e.key) begin
          n_fail++;
          $display("[TB] FAIL rst5 key step %0d: got %h, want %h", i, oRoundKey, e.key);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fips_a1();
    test_back_to_back();
    test_seq_err();
    test_double_flag();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
